svc_delay_pipe: RTL and testbench

- Elastic DEPTH-stage valid/ready delay line. Each accepted word takes at least DEPTH cycles to reach the output.
- Companion to the fixed-latency delay line. Used where the consumer can apply backpressure, so a free-running shift register would drop data.
- Sits between a valid/ready producer and consumer, e.g. to align a stream with a DEPTH-cycle side pipeline.
- Bubbles collapse under stall, so all DEPTH stages can fill.

---
 rtl/svc_delay_pipe.sv | 82 ++++++++
 tb/tb_svc_delay_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/svc_delay_pipe.sv
// svc_delay_pipe: elastic DEPTH-stage valid/ready delay line.
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake, in_data word
//   out_valid/out_ready downstream handshake, out_data word (registered)
//   occupancy          number of valid stages, 0..DEPTH
// Note: out_ready reaches in_ready through a combinational advance chain.
module svc_delay_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [DEPTH:0]              adv;
  logic                        in_xfer, out_xfer;

  // Stage k advances when empty or when the stage after it advances,
  // so bubbles collapse even while the output is stalled.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      adv[DEPTH-1-i] = !v_q[DEPTH-1-i] || adv[DEPTH-i];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_xfer   = in_valid && adv[0];
  assign out_xfer  = v_q[DEPTH-1] && out_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      if (in_valid) d_d[0] = in_data;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_svc_delay_pipe.sv
module tb_svc_delay_pipe;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks   = 0;
  int failures = 0;

  svc_delay_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lat_din  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic       lat_vld  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] lat_dout [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0] lat_occ  [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [7:0] q[$];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       rdy_exp;
    int         acc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_occ",  32'(occupancy), 0);
    check("rst_oval", 32'(out_valid), 0);
    check("rst_odat", 32'(out_data),  0);
    check("rst_irdy", 32'(in_ready),  1);

    // Latency: three back-to-back words with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      in_data  = lat_din[i];
      #1;
      check("lat_irdy", 32'(in_ready), 1);
      tick();
      check("lat_oval", 32'(out_valid), 32'(lat_vld[i]));
      if (lat_vld[i]) check("lat_odat", 32'(out_data), 32'(lat_dout[i]));
      check("lat_occ", 32'(occupancy), 32'(lat_occ[i]));
    end

    // Fill under stall: only three of the offered words fit.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(acc);
      #1;
      rdy_exp = (i < 3);
      check("fill_irdy", 32'(in_ready), 32'(rdy_exp));
      if (rdy_exp) acc++;
      tick();
      if (i >= 2) begin
        check("fill_oval", 32'(out_valid), 1);
        check("fill_odat", 32'(out_data), 32'h A0);
      end
    end
    check("fill_occ", 32'(occupancy), 3);

    // Full pass-through: simultaneous in/out transfers keep occupancy at 3.
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'hB0 + 8'(i);
      #1;
      check("pt_irdy", 32'(in_ready), 1);
      check("pt_oval", 32'(out_valid), 1);
      check("pt_odat", 32'(out_data), (i < 3) ? 32'(8'hA0 + 8'(i)) : 32'(8'hB0 + 8'(i - 3)));
      tick();
      check("pt_occ", 32'(occupancy), 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dr_oval", 32'(out_valid), 1);
      check("dr_odat", 32'(out_data), 32'(8'hB7 + 8'(i)));
      tick();
    end
    check("dr_oval_end", 32'(out_valid), 0);
    check("dr_occ_end",  32'(occupancy), 0);

    // Bubble collapse: 0x01, two idle cycles, 0x02, all under stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h02; tick();
    in_valid = 1'b0; tick();
    check("bub_occ",  32'(occupancy), 2);
    check("bub_odat", 32'(out_data), 32'h01);
    check("bub_irdy", 32'(in_ready), 1);
    out_ready = 1'b1;
    #1;
    check("bub_o1v", 32'(out_valid), 1);
    check("bub_o1d", 32'(out_data), 32'h01);
    tick();
    check("bub_o2v", 32'(out_valid), 1);
    check("bub_o2d", 32'(out_data), 32'h02);
    tick();
    check("bub_empty", 32'(out_valid), 0);
    check("bub_occ0",  32'(occupancy), 0);

    // Random traffic against a queue scoreboard.
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      #1;
      if (prev_stall) begin
        check("rnd_hold_v", 32'(out_valid), 1);
        check("rnd_hold_d", 32'(out_data), 32'(prev_data));
      end
      rdy_exp = (q.size() < DEPTH) || out_ready;
      check("rnd_irdy", 32'(in_ready), 32'(rdy_exp));
      if (out_valid) check("rnd_ov_word", 32'(q.size() > 0), 1);
      if (out_valid && out_ready && q.size() > 0) begin
        check("rnd_odat", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (in_valid && rdy_exp) q.push_back(in_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      check("rnd_occ", 32'(occupancy), 32'(q.size()));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && q.size() > 0) begin
        check("rnd_drain_d", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
      tick();
    end
    check("rnd_drain_q",  32'(q.size()), 0);
    check("rnd_drain_ov", 32'(out_valid), 0);

    // Reset in mid-operation discards in-flight words.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    check("mr_occ2", 32'(occupancy), 2);
    rst = 1'b1; in_data = 8'hC3; tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mr_occ",  32'(occupancy), 0);
    check("mr_oval", 32'(out_valid), 0);
    check("mr_odat", 32'(out_data),  0);
    check("mr_irdy", 32'(in_ready),  1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mr_quiet", 32'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
